// File: rtl/sigmoid_sched_pkg.sv
// rtl/sigmoid_sched_pkg.sv - shared state encoding and Q16.16 constants for sigmoid_sched
package sigmoid_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FX_ONE  = 32'h0001_0000;
    localparam logic [31:0] FX_HALF = 32'h0000_8000;

endpackage

// File: rtl/sigmoid_sched_rr_pick.sv
// rtl/sigmoid_sched_rr_pick.sv - combinational round-robin picker, search starts just above last
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic          found;
    logic [IW-1:0] sel;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        any     = |req;
        // Walk NREQ positions from last+1; the lane just served is visited last.
        for (int k = 1; k <= NREQ; k++) begin
            sel = IW'((int'(last) + k) % NREQ);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt_idx  = sel;
                gnt[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigmoid_sched.sv
// rtl/sigmoid_sched.sv - round-robin scheduler sharing one sigmoid engine among NREQ lanes
module sigmoid_sched
    import sigmoid_sched_pkg::*;
#(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      rsp_y,
    output logic              eng_start,
    output logic [N-1:0]      eng_x,
    input  logic              eng_done,
    input  logic [N-1:0]      eng_y,
    output logic              busy,
    output logic              err_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    logic [IW-1:0]   last_grant, grant_q;
    logic [N-1:0]    x_q, y_q;
    logic [TW-1:0]   timer;
    logic            err_q;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            timer_last;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req_valid),
        .last    (last_grant),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign timer_last = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        case (state)
            IDLE: begin
                // Gated so an asserted reset never shows an accept strobe.
                if (pick_any && rst_n) begin
                    req_ready = pick_gnt;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (eng_done || timer_last) state_n = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(NREQ - 1);
            grant_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            timer      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        x_q     <= req_x[pick_idx*N +: N];
                        grant_q <= pick_idx;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // A done arriving on the final WAIT cycle beats the timeout.
                    if (eng_done) begin
                        y_q <= eng_y;
                    end else if (timer_last) begin
                        y_q   <= N'(FX_HALF);
                        err_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_q]) last_grant <= grant_q;
                end
                default: ;
            endcase
        end
    end

    assign eng_x       = x_q;
    assign rsp_y       = y_q;
    assign busy        = (state != IDLE);
    assign err_timeout = err_q;

endmodule
